// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and fetch/decode/execute sequencer
module pc_sequencer #(
  parameter int PC_W        = 10,
  parameter int INSTR_W     = 9,
  parameter int PGM_LEN     = 64,
  parameter int BR_OFFSET   = 7,
  parameter int JMP_BACK    = 14,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               CLK,
  input  logic               init_n,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               branch_en,
  input  logic               jump_en,
  input  logic               halt_req,
  output logic [PC_W-1:0]    PC,
  output logic               halt,
  output logic               trap,
  output logic [2:0]         state,
  output logic [15:0]        instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0]   TO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [PC_W:0]   BR_W    = (PC_W+1)'(BR_OFFSET);
  localparam logic [PC_W:0]   JMP_W   = (PC_W+1)'(JMP_BACK);
  localparam logic [PC_W:0]   PGM_LIM = (PC_W+1)'(PGM_LEN);

  state_t          st;
  logic [TW-1:0]   tcnt;
  logic [PC_W:0]   pc_ext;
  logic [PC_W:0]   nxt;
  logic            jump_ok;

  assign state     = st;
  assign imem_req  = (st == S_FETCH);
  assign imem_addr = PC;
  assign pc_ext    = {1'b0, PC};
  assign jump_ok   = (pc_ext >= JMP_W);

  // One bit wider than PC so running off the end shows up as a carry, not a wrap.
  always_comb begin
    nxt = pc_ext + {{PC_W{1'b0}}, 1'b1};
    if (branch_en)
      nxt = pc_ext + BR_W;
    else if (jump_en)
      nxt = pc_ext - JMP_W;
  end

  always_ff @(posedge CLK) begin
    if (!init_n) begin
      st          <= S_IDLE;
      PC          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halt        <= 1'b0;
      trap        <= 1'b0;
      instr_count <= '0;
      tcnt        <= '0;
    end else begin
      instr_valid <= 1'b0;
      case (st)
        S_IDLE: begin
          if (start)
            st <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr       <= imem_data;
            tcnt        <= '0;
            instr_valid <= 1'b1;
            st          <= S_DECODE;
          end else if (tcnt == TO_LAST) begin
            tcnt <= '0;
            trap <= 1'b1;
            halt <= 1'b1;
            st   <= S_HALT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DECODE: st <= S_EXEC;
        S_EXEC: begin
          if (exec_done) begin
            if (instr_count != 16'hFFFF)
              instr_count <= instr_count + 16'd1;
            if (halt_req) begin
              halt <= 1'b1;
              st   <= S_HALT;
            end else if (!branch_en && jump_en && !jump_ok) begin
              trap <= 1'b1;
              halt <= 1'b1;
              st   <= S_HALT;
            end else if (nxt >= PGM_LIM) begin
              PC   <= nxt[PC_W-1:0];
              halt <= 1'b1;
              st   <= S_HALT;
            end else begin
              PC <= nxt[PC_W-1:0];
              st <= S_FETCH;
            end
          end
        end
        S_HALT: st <= S_HALT;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle program-flow controller for the core. Owns the program counter and fetches each instruction from instruction memory over a req/ack handshake. It presents the latched instruction to the decoder, waits for the datapath to finish executing, and then resolves the next PC (sequential, forward branch, backward jump, halt or trap). It sits between instruction memory, the decoder and the execute datapath, and replaces the free-running PC update with an explicit fetch/decode/execute sequence.

Parameters:
PC_W, 10, program counter width
INSTR_W, 9, instruction width
PGM_LEN, 64, number of legal instruction addresses (0..PGM_LEN-1)
BR_OFFSET, 7, forward displacement applied on branch
JMP_BACK, 14, backward displacement applied on jump
ACK_TIMEOUT, 15, max FETCH cycles without imem_ack before trap

Ports:
CLK  in  1  clock, all logic on rising edge
init_n  in  1  synchronous active-low reset
start  in  1  begin execution; honoured only in IDLE
imem_req  out  1  fetch request; high for every FETCH cycle
imem_addr  out  PC_W  fetch address, always equals PC
imem_ack  in  1  instruction memory has imem_data valid this cycle
imem_data  in  INSTR_W  fetched instruction
instr  out  INSTR_W  latched instruction for the decoder
instr_valid  out  1  one-cycle pulse in DECODE
exec_done  in  1  datapath finished the current instruction; sampled only in EXEC
branch_en  in  1  take forward branch; sampled with exec_done
jump_en  in  1  take backward jump; sampled with exec_done
halt_req  in  1  halt instruction retired; sampled with exec_done
PC  out  PC_W  program counter
halt  out  1  sticky; machine stopped
trap  out  1  sticky; error stop (implies halt)
state  out  3  FSM state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4
instr_count  out  16  retired instructions, saturating

Behaviour:
- Reset (init_n=0 at an edge) from any state, including mid-fetch: state=IDLE, PC=0, instr=0, instr_valid=0, halt=0, trap=0, instr_count=0, timeout counter=0. imem_req drops in the cycle after that edge. Registers only; no combinational path from init_n.
- IDLE: wait. start=1 leads to FETCH on the next edge. start is ignored in every other state.
- FETCH: imem_req=1 (decoded from state), imem_addr=PC. On an edge with imem_ack=1: instr<=imem_data, timeout counter cleared, go to DECODE. Each edge without ack increments the timeout counter. If ACK_TIMEOUT consecutive FETCH cycles pass with no ack: trap<=1, halt<=1, go to HALT, PC unchanged.
- DECODE: exactly one cycle. instr_valid=1 (registered, high only while state==DECODE). Then go to EXEC.
- EXEC: hold until exec_done=1. On that edge: instr_count+=1, saturating at 0xFFFF. The next PC is resolved with this priority:
  1. halt_req: PC unchanged, halt<=1, go to HALT.
  2. branch_en: next = PC + BR_OFFSET.
  3. jump_en with PC >= JMP_BACK: next = PC - JMP_BACK.
  4. jump_en with PC < JMP_BACK: trap<=1, halt<=1, PC unchanged, go to HALT.
  5. otherwise: next = PC + 1.
- Range check for cases 2, 3 and 5: the sum is computed PC_W+1 bits wide.
  - If next >= PGM_LEN (or carry out): PC<=next[PC_W-1:0], halt<=1, trap stays 0, go to HALT. Running off the end is a normal stop, not an error.
  - Otherwise PC<=next, go to FETCH.
- branch_en and jump_en both high: branch wins; jump is ignored with no trap.
- HALT: absorbing state. No imem_req, PC frozen, halt=1; only init_n leaves it.
- halt and trap never deassert except by reset. trap=1 always implies halt=1.
- Latency for a sequential instruction with a 1-cycle ack: FETCH(1) + DECODE(1) + EXEC(n) cycles.

Test Plan:
- Reset then start, imem_ack same cycle, exec_done 1 cycle after DECODE, no control inputs -> PC steps 0,1,2,...; each instruction takes 3 cycles; instr_count=3 after 3 retirements; instr_valid pulses once per instruction.
- PC=5, branch_en with exec_done -> PC=12, next imem_addr=12. Then PC=20, jump_en -> PC=6. Then PC=6, jump_en -> trap=1, halt=1, PC stays 6, state=HALT.
- PC=60, branch_en -> PC=67, halt=1, trap=0, imem_req never asserted again. Separately, PC=63 sequential -> PC=64, halt=1.
- imem_ack withheld for 15 FETCH cycles -> trap=1, halt=1 on the 15th edge. A variant acking on the 14th cycle proceeds normally to DECODE.
- branch_en and jump_en both high at PC=3 -> PC=10, no trap. halt_req with branch_en -> halt=1, PC unchanged.
- init_n pulsed low during FETCH with imem_req=1, and again while in HALT with trap=1 -> next cycle: state=IDLE, PC=0, halt=0, trap=0, imem_req=0, instr_count=0. start asserted during EXEC is ignored.
